// File: rtl/friscv_pkg.sv
// Shared definitions for the FRiscV core: controller states, ALU operation
// encoding, RV32I opcodes and datapath mux selects.
package friscv_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_I    = 4'd3,
        ST_ALU_WB    = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_BR_TAKE   = 4'd10,
        ST_JAL       = 4'd11,
        ST_TRAP      = 4'd12
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_DMEM    = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;
    localparam logic [1:0] RES_PC      = 2'b11;

endpackage

// File: rtl/friscv_alu_dec.sv
// Combinational func3/func7 to ALU operation decoder for R-type and I-type
// ALU instructions; also flags encodings that are not valid RV32I.
module friscv_alu_dec
    import friscv_pkg::*;
(
    input  logic [2:0] func3_in,
    input  logic [6:0] func7_in,
    input  logic       is_imm_in,
    output alu_ctrl_t  alu_ctrl_out,
    output logic       illegal_out
);

    logic f7_known;

    assign f7_known = (func7_in == F7_BASE) || (func7_in == F7_ALT);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        alu_ctrl_out = ALU_ADD;
        illegal_out  = 1'b0;

        unique case (func3_in)
            3'b000: alu_ctrl_out = (!is_imm_in && func7_in[5]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctrl_out = ALU_SLL;
            3'b010: alu_ctrl_out = ALU_SLT;
            3'b011: alu_ctrl_out = ALU_SLTU;
            3'b100: alu_ctrl_out = ALU_XOR;
            3'b101: alu_ctrl_out = func7_in[5] ? ALU_SRA : ALU_SRL;
            3'b110: alu_ctrl_out = ALU_OR;
            3'b111: alu_ctrl_out = ALU_AND;
            default: alu_ctrl_out = ALU_ADD;
        endcase

        // For I-type, func7 is immediate bits except on the shift encodings.
        if (is_imm_in) begin
            if (func3_in == 3'b001 && func7_in != F7_BASE)
                illegal_out = 1'b1;
            if (func3_in == 3'b101 && !f7_known)
                illegal_out = 1'b1;
        end else begin
            if (!f7_known)
                illegal_out = 1'b1;
            if (func7_in == F7_ALT && func3_in != 3'b000 && func3_in != 3'b101)
                illegal_out = 1'b1;
        end
    end

endmodule

// File: rtl/friscv_ctrl_fsm.sv
// Multi-cycle main controller for the FRiscV core: Moore FSM driving datapath
// enables, mux selects and ALU op; counts retired instructions, traps on illegal.
module friscv_ctrl_fsm
    import friscv_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op_code_in,
    input  logic [2:0]           func3_in,
    input  logic [6:0]           func7_in,
    input  logic                 zero_in,
    output logic                 ir_we_out,
    output logic                 pc_we_out,
    output logic                 reg_we_out,
    output logic                 dmem_we_out,
    output logic [1:0]           alu_src_a_sel_out,
    output logic [1:0]           alu_src_b_sel_out,
    output logic [1:0]           result_src_sel_out,
    output logic [3:0]           alu_ctrl_out,
    output logic                 trap_out,
    output logic [CNT_WIDTH-1:0] retired_cnt_out
);

    ctrl_state_t          state_q, state_d;
    logic                 taken_q, taken_d;
    logic                 trap_q, trap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    alu_ctrl_t dec_alu_ctrl;
    logic      dec_illegal;
    logic      retire;

    // Decoder inputs stay valid through EXEC_R/EXEC_I, so one decoder serves
    // both the legality check in DECODE and the op select in execute.
    friscv_alu_dec u_alu_dec (
        .func3_in     (func3_in),
        .func7_in     (func7_in),
        .is_imm_in    (op_code_in == OPC_OP_IMM),
        .alu_ctrl_out (dec_alu_ctrl),
        .illegal_out  (dec_illegal)
    );

    // NOTE: state registers use non-blocking assignments; control state is
    // reset asynchronously so outputs fall to zero the moment rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            taken_q <= 1'b0;
            trap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            trap_q  <= trap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        taken_d            = taken_q;
        trap_d             = trap_q;
        retire             = 1'b0;
        ir_we_out          = 1'b0;
        pc_we_out          = 1'b0;
        reg_we_out         = 1'b0;
        dmem_we_out        = 1'b0;
        alu_src_a_sel_out  = SRC_A_PC;
        alu_src_b_sel_out  = SRC_B_RS2;
        result_src_sel_out = RES_ALU_OUT;
        alu_ctrl_out       = ALU_ADD;

        unique case (state_q)
            ST_FETCH: state_d = ST_DECODE;

            ST_DECODE: begin
                ir_we_out         = 1'b1;
                pc_we_out         = 1'b1;
                alu_src_a_sel_out = SRC_A_PC;
                alu_src_b_sel_out = SRC_B_FOUR;
                unique case (op_code_in)
                    OPC_OP:     state_d = dec_illegal ? ST_TRAP : ST_EXEC_R;
                    OPC_OP_IMM: state_d = dec_illegal ? ST_TRAP : ST_EXEC_I;
                    OPC_LOAD, OPC_STORE:
                        state_d = (func3_in == 3'b010) ? ST_MEM_ADDR : ST_TRAP;
                    OPC_BRANCH:
                        state_d = (func3_in[2:1] == 2'b00) ? ST_BRANCH : ST_TRAP;
                    OPC_JAL:    state_d = ST_JAL;
                    default:    state_d = ST_TRAP;
                endcase
            end

            ST_EXEC_R, ST_EXEC_I: begin
                alu_src_a_sel_out = SRC_A_RS1;
                alu_src_b_sel_out = (state_q == ST_EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
                alu_ctrl_out      = dec_alu_ctrl;
                state_d           = ST_ALU_WB;
            end

            ST_ALU_WB: begin
                reg_we_out = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end

            ST_MEM_ADDR: begin
                alu_src_a_sel_out = SRC_A_RS1;
                alu_src_b_sel_out = SRC_B_IMM;
                state_d = (op_code_in == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            end

            ST_MEM_READ: state_d = ST_MEM_WB;

            ST_MEM_WB: begin
                reg_we_out         = 1'b1;
                result_src_sel_out = RES_DMEM;
                retire             = 1'b1;
                state_d            = ST_FETCH;
            end

            ST_MEM_WRITE: begin
                dmem_we_out = 1'b1;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end

            ST_BRANCH: begin
                alu_src_a_sel_out = SRC_A_RS1;
                alu_src_b_sel_out = SRC_B_RS2;
                alu_ctrl_out      = ALU_SUB;
                // BEQ (func3[0]=0) takes on zero, BNE on non-zero.
                taken_d = zero_in ^ func3_in[0];
                if (taken_d) begin
                    state_d = ST_BR_TAKE;
                end else begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_BR_TAKE: begin
                pc_we_out         = taken_q;
                alu_src_a_sel_out = SRC_A_OLD_PC;
                alu_src_b_sel_out = SRC_B_IMM;
                retire            = 1'b1;
                state_d           = ST_FETCH;
            end

            ST_JAL: begin
                pc_we_out          = 1'b1;
                reg_we_out         = 1'b1;
                alu_src_a_sel_out  = SRC_A_OLD_PC;
                alu_src_b_sel_out  = SRC_B_IMM;
                result_src_sel_out = RES_PC;
                retire             = 1'b1;
                state_d            = ST_FETCH;
            end

            ST_TRAP: state_d = ST_TRAP;

            default: state_d = ST_FETCH;
        endcase

        if (state_d == ST_TRAP)
            trap_d = 1'b1;
    end

    assign cnt_d           = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    assign trap_out        = trap_q;
    assign retired_cnt_out = cnt_q;

endmodule

// File: tb/tb_friscv_ctrl_fsm.sv
// Directed self-checking bench for friscv_ctrl_fsm: walks each instruction
// class cycle by cycle, plus trap and mid-instruction reset.
module tb_friscv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op_code_in;
    logic [2:0]  func3_in;
    logic [6:0]  func7_in;
    logic        zero_in;
    logic        ir_we_out, pc_we_out, reg_we_out, dmem_we_out, trap_out;
    logic [1:0]  alu_src_a_sel_out, alu_src_b_sel_out, result_src_sel_out;
    logic [3:0]  alu_ctrl_out;
    logic [31:0] retired_cnt_out;

    int checks   = 0;
    int failures = 0;

    friscv_ctrl_fsm #(.CNT_WIDTH(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .op_code_in         (op_code_in),
        .func3_in           (func3_in),
        .func7_in           (func7_in),
        .zero_in            (zero_in),
        .ir_we_out          (ir_we_out),
        .pc_we_out          (pc_we_out),
        .reg_we_out         (reg_we_out),
        .dmem_we_out        (dmem_we_out),
        .alu_src_a_sel_out  (alu_src_a_sel_out),
        .alu_src_b_sel_out  (alu_src_b_sel_out),
        .result_src_sel_out (result_src_sel_out),
        .alu_ctrl_out       (alu_ctrl_out),
        .trap_out           (trap_out),
        .retired_cnt_out    (retired_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view of every control output: ir pc reg dmem a b res alu trap.
    function automatic logic [31:0] outs_now();
        return {17'd0, ir_we_out, pc_we_out, reg_we_out, dmem_we_out,
                alu_src_a_sel_out, alu_src_b_sel_out, result_src_sel_out,
                alu_ctrl_out, trap_out};
    endfunction

    function automatic logic [31:0] ev(input bit ir, input bit pc, input bit rg,
                                       input bit dm, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] res,
                                       input logic [3:0] alu, input bit tr);
        return {17'd0, ir, pc, rg, dm, a, b, res, alu, tr};
    endfunction

    task automatic check_outs(input string tag, input logic [31:0] exp);
        check(tag, outs_now(), exp);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z);
        op_code_in = op;
        func3_in   = f3;
        func7_in   = f7;
        zero_in    = z;
    endtask

    localparam logic [31:0] ZERO_OUTS = 32'd0;
    // DECODE: ir_we, pc_we, a=PC, b=4, ADD
    localparam logic [31:0] DEC_OUTS  = {17'd0, 4'b1100, 2'b00, 2'b10, 2'b00, 4'd0, 1'b0};

    initial begin
        rst_n = 1'b0;
        set_instr(7'b0000000, 3'b000, 7'b0000000, 1'b0);
        repeat (3) tick();
        check_outs("reset_outs", ZERO_OUTS);
        check("reset_cnt", retired_cnt_out, 32'd0);
        rst_n = 1'b1;
        check_outs("fetch0", ZERO_OUTS);

        // R-type SUB: 4 cycles
        set_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0);
        tick(); check_outs("sub_decode", DEC_OUTS);
        tick(); check_outs("sub_exec", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'd1, 0));
        tick(); check_outs("sub_wb", ev(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0));
        check("sub_cnt_before", retired_cnt_out, 32'd0);
        tick(); check_outs("sub_fetch", ZERO_OUTS);
        check("sub_cnt", retired_cnt_out, 32'd1);

        // R-type SLTU
        set_instr(7'b0110011, 3'b011, 7'b0000000, 1'b0);
        tick(); check_outs("sltu_decode", DEC_OUTS);
        tick(); check_outs("sltu_exec", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'd6, 0));
        tick(); tick();
        check("sltu_cnt", retired_cnt_out, 32'd2);

        // I-type SRAI
        set_instr(7'b0010011, 3'b101, 7'b0100000, 1'b0);
        tick(); check_outs("srai_decode", DEC_OUTS);
        tick(); check_outs("srai_exec", ev(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'd9, 0));
        tick(); check_outs("srai_wb", ev(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0));
        tick(); check("srai_cnt", retired_cnt_out, 32'd3);

        // I-type ADDI with func7 bits set: must stay ADD
        set_instr(7'b0010011, 3'b000, 7'b0100000, 1'b0);
        tick(); tick();
        check_outs("addi_exec", ev(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'd0, 0));
        tick(); tick();
        check("addi_cnt", retired_cnt_out, 32'd4);

        // LW: 5 cycles
        set_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
        tick(); check_outs("lw_decode", DEC_OUTS);
        tick(); check_outs("lw_addr", ev(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'd0, 0));
        tick(); check_outs("lw_read", ZERO_OUTS);
        tick(); check_outs("lw_wb", ev(0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 4'd0, 0));
        tick(); check_outs("lw_fetch", ZERO_OUTS);
        check("lw_cnt", retired_cnt_out, 32'd5);

        // SW: 4 cycles, one dmem_we
        set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
        tick(); check_outs("sw_decode", DEC_OUTS);
        tick(); check_outs("sw_addr", ev(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'd0, 0));
        tick(); check_outs("sw_write", ev(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0));
        tick(); check_outs("sw_fetch", ZERO_OUTS);
        check("sw_cnt", retired_cnt_out, 32'd6);

        // BEQ taken
        set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1);
        tick(); check_outs("beq_t_decode", DEC_OUTS);
        tick(); check_outs("beq_t_branch", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'd1, 0));
        tick(); check_outs("beq_t_take", ev(0, 1, 0, 0, 2'b01, 2'b01, 2'b00, 4'd0, 0));
        tick(); check_outs("beq_t_fetch", ZERO_OUTS);
        check("beq_t_cnt", retired_cnt_out, 32'd7);

        // BEQ not taken: 3 cycles
        set_instr(7'b1100011, 3'b000, 7'b0000000, 1'b0);
        tick(); tick();
        check_outs("beq_n_branch", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'd1, 0));
        tick(); check_outs("beq_n_fetch", ZERO_OUTS);
        check("beq_n_cnt", retired_cnt_out, 32'd8);

        // BNE with zero=0: taken
        set_instr(7'b1100011, 3'b001, 7'b0000000, 1'b0);
        tick(); tick();
        tick(); check_outs("bne_take", ev(0, 1, 0, 0, 2'b01, 2'b01, 2'b00, 4'd0, 0));
        tick(); check("bne_cnt", retired_cnt_out, 32'd9);

        // JAL: 3 cycles
        set_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
        tick(); check_outs("jal_decode", DEC_OUTS);
        tick(); check_outs("jal_exec", ev(0, 1, 1, 0, 2'b01, 2'b01, 2'b11, 4'd0, 0));
        tick(); check_outs("jal_fetch", ZERO_OUTS);
        check("jal_cnt", retired_cnt_out, 32'd10);

        // Illegal opcode: terminal TRAP, counter frozen
        set_instr(7'b1111111, 3'b000, 7'b0000000, 1'b0);
        tick(); check_outs("ill_decode", DEC_OUTS);
        tick(); check_outs("ill_trap", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1));
        set_instr(7'b0110011, 3'b000, 7'b0000000, 1'b0);
        repeat (12) tick();
        check_outs("ill_trap_held", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1));
        check("ill_cnt_frozen", retired_cnt_out, 32'd10);

        // Reset clears trap and counter
        rst_n = 1'b0;
        #1;
        check_outs("rst_trap_outs", ZERO_OUTS);
        check("rst_trap_cnt", retired_cnt_out, 32'd0);
        tick();
        rst_n = 1'b1;

        // Illegal R-type: func7=0100000 with func3=111
        set_instr(7'b0110011, 3'b111, 7'b0100000, 1'b0);
        tick(); tick();
        check("ill_r_trap", {31'd0, trap_out}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Illegal load func3
        set_instr(7'b0000011, 3'b000, 7'b0000000, 1'b0);
        tick(); tick();
        check("ill_lb_trap", {31'd0, trap_out}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // SW retires once, then reset asserted mid MEM_WRITE of a second SW
        set_instr(7'b0100011, 3'b010, 7'b0000000, 1'b0);
        repeat (4) tick();
        check("sw2_cnt", retired_cnt_out, 32'd1);
        tick(); tick(); tick();
        check_outs("sw3_write", ev(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("midrst_outs", ZERO_OUTS);
        check("midrst_cnt", retired_cnt_out, 32'd0);
        tick();
        check_outs("midrst_held", ZERO_OUTS);
        rst_n = 1'b1;
        check_outs("midrst_fetch", ZERO_OUTS);
        tick(); check_outs("midrst_restart_decode", DEC_OUTS);
        check("midrst_cnt_after", retired_cnt_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
